// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite layer sequencer.
// Contents: default geometry and colour constants, the FSM state encoding,
// and a helper that sizes layer-index fields (at least one bit wide).
package sprite_pkg;

    localparam int          SPR_NUM_LAYERS  = 4;
    localparam int          SPR_ID_W        = 5;
    localparam int          SPR_ADDR_W      = 12;
    localparam int          SPR_PIX_W       = 24;
    localparam logic [23:0] SPR_TRANSPARENT = 24'h000011;
    localparam logic [23:0] SPR_BG_COLOR    = 24'h000000;
    localparam int          SPR_MEM_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_OUT   = 3'd4
    } seq_state_t;

    function automatic int layer_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_next_layer.sv
// Combinational priority pick of the lowest-numbered set bit of mask whose
// index is >= start.
// Ports:
//   mask   in   NUM_LAYERS  candidate layers
//   start  in   IDX_W+1     first index considered; one extra bit so that
//                           cur+1 past the last layer means "none left"
//   index  out  IDX_W       lowest qualifying layer (0 when none)
//   found  out  1           a qualifying layer exists
module sprite_next_layer
    import sprite_pkg::*;
#(
    parameter  int NUM_LAYERS = SPR_NUM_LAYERS,
    localparam int IDX_W      = layer_idx_w(NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0] mask,
    input  logic [IDX_W:0]        start,
    output logic [IDX_W-1:0]      index,
    output logic                  found
);

    // Scanning downward lets the lowest qualifying index overwrite the rest.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_layer_sequencer.sv
// Composites one output pixel from up to NUM_LAYERS sprite layers by reading
// one word per enabled layer, in priority order, from the shared sprite
// memory port and stopping at the first opaque word.
// Ports:
//   clock, reset       system clock; asynchronous active-high reset
//   pix_req/pix_ready  request handshake (accepted only in IDLE)
//   pix_offset, layer_enable, layer_sprite_id
//                      per-pixel configuration, registered on accept
//   mem_rd_en/mem_addr/mem_rd_data
//                      sprite memory read port, data MEM_LATENCY cycles later
//   pixel, Saida_R/G/B composited pixel and its byte slices (registered)
//   pixel_valid        one-cycle strobe while the new pixel is presented
//   layer_hit/hit_none winning layer, or background flag
//
// state  | meaning
// IDLE   | ready for a request; config is captured on accept
// ISSUE  | one-cycle read strobe for layer cur
// WAIT   | remaining MEM_LATENCY-1 cycles of read latency
// EVAL   | read data valid; opaque ends the search, transparent moves on
// OUT    | result registers hold the new pixel; pixel_valid high
module sprite_layer_sequencer
    import sprite_pkg::*;
#(
    parameter  int               NUM_LAYERS  = SPR_NUM_LAYERS,
    parameter  int               ID_W        = SPR_ID_W,
    parameter  int               ADDR_W      = SPR_ADDR_W,
    parameter  int               PIX_W       = SPR_PIX_W,
    parameter  logic [PIX_W-1:0] TRANSPARENT = SPR_TRANSPARENT,
    parameter  logic [PIX_W-1:0] BG_COLOR    = SPR_BG_COLOR,
    parameter  int               MEM_LATENCY = SPR_MEM_LATENCY,
    localparam int               IDX_W       = layer_idx_w(NUM_LAYERS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       pix_req,
    output logic                       pix_ready,
    input  logic [ADDR_W-1:0]          pix_offset,
    input  logic [NUM_LAYERS-1:0]      layer_enable,
    input  logic [NUM_LAYERS*ID_W-1:0] layer_sprite_id,
    output logic                       mem_rd_en,
    output logic [ID_W+ADDR_W-1:0]     mem_addr,
    input  logic [PIX_W-1:0]           mem_rd_data,
    output logic [PIX_W-1:0]           pixel,
    output logic [7:0]                 Saida_R,
    output logic [7:0]                 Saida_G,
    output logic [7:0]                 Saida_B,
    output logic                       pixel_valid,
    output logic [IDX_W-1:0]           layer_hit,
    output logic                       hit_none
);

    localparam int WCNT_W = 2;
    localparam logic [WCNT_W-1:0] WAIT_LOAD =
        WCNT_W'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);

    seq_state_t state, state_d;

    logic [IDX_W-1:0]           cur;
    logic [ADDR_W-1:0]          offset_q;
    logic [NUM_LAYERS-1:0]      enable_q;
    logic [NUM_LAYERS*ID_W-1:0] ids_q;
    logic [WCNT_W-1:0]          wait_cnt;
    logic [ID_W+ADDR_W-1:0]     addr_q;
    logic [PIX_W-1:0]           pixel_q;
    logic [IDX_W-1:0]           hit_q;
    logic                       none_q;

    logic [NUM_LAYERS-1:0]      pick_mask;
    logic [IDX_W:0]             pick_start;
    logic [IDX_W-1:0]           pick_index;
    logic                       pick_found;

    logic                       load_cfg;
    logic                       issue_load;
    logic                       result_load;
    logic                       result_bg;

    logic [NUM_LAYERS*ID_W-1:0] sel_ids;
    logic [ADDR_W-1:0]          sel_offset;

    // One picker serves both IDLE (live inputs, start 0) and EVAL
    // (registered mask, start just above the layer that was transparent).
    sprite_next_layer #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_next_layer (
        .mask  (pick_mask),
        .start (pick_start),
        .index (pick_index),
        .found (pick_found)
    );

    always_comb begin
        state_d     = state;
        pick_mask   = enable_q;
        pick_start  = {1'b0, cur} + 1'b1;
        load_cfg    = 1'b0;
        issue_load  = 1'b0;
        result_load = 1'b0;
        result_bg   = 1'b0;
        sel_ids     = ids_q;
        sel_offset  = offset_q;

        case (state)
            ST_IDLE: begin
                pick_mask  = layer_enable;
                pick_start = '0;
                sel_ids    = layer_sprite_id;
                sel_offset = pix_offset;
                if (pix_req) begin
                    load_cfg = 1'b1;
                    if (pick_found) begin
                        issue_load = 1'b1;
                        state_d    = ST_ISSUE;
                    end else begin
                        result_load = 1'b1;
                        result_bg   = 1'b1;
                        state_d     = ST_OUT;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = (MEM_LATENCY > 1) ? ST_WAIT : ST_EVAL;
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (mem_rd_data != TRANSPARENT) begin
                    result_load = 1'b1;
                    state_d     = ST_OUT;
                end else if (pick_found) begin
                    issue_load = 1'b1;
                    state_d    = ST_ISSUE;
                end else begin
                    result_load = 1'b1;
                    result_bg   = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            offset_q <= '0;
            enable_q <= '0;
            ids_q    <= '0;
            cur      <= '0;
            addr_q   <= '0;
            wait_cnt <= '0;
        end else begin
            if (load_cfg) begin
                offset_q <= pix_offset;
                enable_q <= layer_enable;
                ids_q    <= layer_sprite_id;
            end
            if (issue_load) begin
                cur    <= pick_index;
                addr_q <= {sel_ids[int'(pick_index)*ID_W +: ID_W], sel_offset};
            end
            if (state == ST_ISSUE) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // Results load on the edge into OUT so they are stable for the whole
    // strobe cycle and held until the next pixel completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_q <= '0;
            hit_q   <= '0;
            none_q  <= 1'b0;
        end else if (result_load) begin
            if (result_bg) begin
                pixel_q <= BG_COLOR;
                hit_q   <= '0;
                none_q  <= 1'b1;
            end else begin
                pixel_q <= mem_rd_data;
                hit_q   <= cur;
                none_q  <= 1'b0;
            end
        end
    end

    assign pix_ready   = (state == ST_IDLE) && !reset;
    assign mem_rd_en   = (state == ST_ISSUE);
    assign mem_addr    = addr_q;
    assign pixel_valid = (state == ST_OUT);
    assign pixel       = pixel_q;
    assign Saida_R     = pixel_q[7:0];
    assign Saida_G     = pixel_q[15:8];
    assign Saida_B     = pixel_q[23:16];
    assign layer_hit   = hit_q;
    assign hit_none    = none_q;

endmodule

// File: tb/tb_sprite_layer_sequencer.sv
// Scoreboard bench for sprite_layer_sequencer. Instance A uses a one-cycle
// memory, instance B a three-cycle memory; both share config inputs and reset.
module tb_sprite_layer_sequencer;
    import sprite_pkg::*;

    typedef struct {
        logic [23:0] pix;
        logic [1:0]  hit;
        logic        none;
        int          at;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [11:0] off_s = '0;
    logic [3:0]  en_s  = '0;
    logic [19:0] ids_s = '0;

    logic        req_a = 1'b0, req_b = 1'b0;
    logic        ready_a, ready_b, rd_en_a, rd_en_b, valid_a, valid_b, none_a, none_b;
    logic [16:0] addr_a, addr_b;
    logic [23:0] rd_data_a, rd_data_b, pixel_a, pixel_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic [1:0]  hit_a, hit_b;
    logic [23:0] pb [3];

    sprite_layer_sequencer #(.MEM_LATENCY(1)) u_a (
        .clock(clock), .reset(reset), .pix_req(req_a), .pix_ready(ready_a),
        .pix_offset(off_s), .layer_enable(en_s), .layer_sprite_id(ids_s),
        .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_rd_data(rd_data_a),
        .pixel(pixel_a), .Saida_R(r_a), .Saida_G(g_a), .Saida_B(b_a),
        .pixel_valid(valid_a), .layer_hit(hit_a), .hit_none(none_a)
    );

    sprite_layer_sequencer #(.MEM_LATENCY(3)) u_b (
        .clock(clock), .reset(reset), .pix_req(req_b), .pix_ready(ready_b),
        .pix_offset(off_s), .layer_enable(en_s), .layer_sprite_id(ids_s),
        .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rd_data(rd_data_b),
        .pixel(pixel_b), .Saida_R(r_b), .Saida_G(g_b), .Saida_B(b_b),
        .pixel_valid(valid_b), .layer_hit(hit_b), .hit_none(none_b)
    );

    logic [23:0] mem [int];

    function automatic int key(input int id, input int off);
        return (id << 12) | off;
    endfunction

    function automatic logic [23:0] lookup(input logic [16:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : 24'hDEAD00;
    endfunction

    function automatic logic [19:0] pack(input int i0, input int i1, input int i2, input int i3);
        return {5'(i3), 5'(i2), 5'(i1), 5'(i0)};
    endfunction

    // Memory models: data only valid exactly MEM_LATENCY cycles after a read.
    always @(posedge clock) begin
        rd_data_a <= rd_en_a ? lookup(addr_a) : 24'hBAD000;
        pb[0]     <= rd_en_b ? lookup(addr_b) : 24'hBAD000;
        pb[1]     <= pb[0];
        pb[2]     <= pb[1];
    end
    assign rd_data_b = pb[2];

    exp_t        qa[$], qb[$];
    logic [16:0] ra[$], rb[$];
    exp_t        ea, eb;
    logic [16:0] xa, xb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (valid_a) begin
            if (qa.size() == 0) check("a_unexpected_valid", 1, 0);
            else begin
                ea = qa.pop_front();
                check("a_pixel", 32'(pixel_a), 32'(ea.pix));
                check("a_saida_r", 32'(r_a), 32'(ea.pix[7:0]));
                check("a_saida_g", 32'(g_a), 32'(ea.pix[15:8]));
                check("a_saida_b", 32'(b_a), 32'(ea.pix[23:16]));
                check("a_layer_hit", 32'(hit_a), 32'(ea.hit));
                check("a_hit_none", 32'(none_a), 32'(ea.none));
                check("a_latency", 32'(cyc), 32'(ea.at));
            end
        end
        if (rd_en_a) begin
            if (ra.size() == 0) check("a_unexpected_read", 32'(addr_a), 0);
            else begin
                xa = ra.pop_front();
                check("a_read_addr", 32'(addr_a), 32'(xa));
            end
        end
    end

    always @(negedge clock) begin
        if (valid_b) begin
            if (qb.size() == 0) check("b_unexpected_valid", 1, 0);
            else begin
                eb = qb.pop_front();
                check("b_pixel", 32'(pixel_b), 32'(eb.pix));
                check("b_saida_b", 32'(b_b), 32'(eb.pix[23:16]));
                check("b_layer_hit", 32'(hit_b), 32'(eb.hit));
                check("b_hit_none", 32'(none_b), 32'(eb.none));
                check("b_latency", 32'(cyc), 32'(eb.at));
            end
        end
        if (rd_en_b) begin
            if (rb.size() == 0) check("b_unexpected_read", 32'(addr_b), 0);
            else begin
                xb = rb.pop_front();
                check("b_read_addr", 32'(addr_b), 32'(xb));
            end
        end
    end

    // Issues one request (held for reps back-to-back pixels) and pushes the
    // hand-computed result plus the addresses of the first n enabled layers.
    task automatic drive(input bit use_b, input logic [11:0] off, input logic [3:0] en,
                         input logic [19:0] ids, input int n, input logic [23:0] pix,
                         input logic [1:0] hit, input logic none, input int reps);
        int   ml, per, k, waited;
        exp_t e;
        ml = use_b ? 3 : 1;
        per = n * (1 + ml);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (!(use_b ? ready_b : ready_a) && waited < 50);
        if (!(use_b ? ready_b : ready_a)) begin
            check("ready_timeout", 0, 1);
            return;
        end
        off_s = off; en_s = en; ids_s = ids;
        if (use_b) req_b = 1'b1; else req_a = 1'b1;
        for (int r = 0; r < reps; r++) begin
            e.pix = pix; e.hit = hit; e.none = none;
            e.at = cyc + 1 + per + r * (2 + per);
            if (use_b) qb.push_back(e); else qa.push_back(e);
            k = 0;
            for (int i = 0; i < 4; i++) begin
                if (en[i] && k < n) begin
                    if (use_b) rb.push_back({ids[i*5 +: 5], off});
                    else       ra.push_back({ids[i*5 +: 5], off});
                    k++;
                end
            end
        end
        repeat (1 + (reps - 1) * (2 + per)) @(posedge clock);
        #1;
        req_a = 1'b0; req_b = 1'b0;
        // Config is sampled on accept only; scrambling it must not matter.
        en_s = 4'($urandom); ids_s = 20'($urandom); off_s = 12'($urandom);
    endtask

    initial begin
        mem[key(1, 'h010)] = 24'hFF0000;
        mem[key(5, 'h020)] = 24'h000011;
        mem[key(6, 'h020)] = 24'h00AA00;
        for (int i = 9; i <= 12; i++) mem[key(i, 'h030)] = 24'h000011;
        mem[key(13, 'h040)] = 24'h000011;
        mem[key(14, 'h040)] = 24'hFFFFFF;
        mem[key(15, 'h040)] = 24'h123456;
        mem[key(18, 'h050)] = 24'h000011;
        mem[key(20, 'h050)] = 24'h000011;
        mem[key(21, 'h060)] = 24'h000010;
        mem[key(22, 'h061)] = 24'hC0FFEE;
        mem[key(23, 'h070)] = 24'h00BEEF;
        mem[key(3, 'h100)]  = 24'h0000FF;
        mem[key(1, 'h200)]  = 24'h777777;
        mem[key(5, 'h210)]  = 24'h000011;
        mem[key(6, 'h210)]  = 24'hABCDEF;

        repeat (3) @(negedge clock);
        check("rst_ready", 32'(ready_a), 0);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_rd_en", 32'(rd_en_a), 0);
        check("rst_pixel", 32'(pixel_a), 0);
        check("rst_addr", 32'(addr_a), 0);
        check("rst_hit", 32'(hit_a), 0);
        check("rst_none", 32'(none_a), 0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", 32'(ready_a), 1);

        drive(0, 12'h010, 4'b1111, pack(1, 2, 3, 4), 1, 24'hFF0000, 2'd0, 1'b0, 1);
        drive(0, 12'h031, 4'b0000, pack(1, 2, 3, 4), 0, 24'h000000, 2'd0, 1'b1, 1);
        drive(0, 12'h020, 4'b1111, pack(5, 6, 7, 8), 2, 24'h00AA00, 2'd1, 1'b0, 1);
        drive(0, 12'h030, 4'b1111, pack(9, 10, 11, 12), 4, 24'h000000, 2'd0, 1'b1, 1);
        drive(0, 12'h040, 4'b0101, pack(13, 14, 15, 16), 2, 24'h123456, 2'd2, 1'b0, 1);
        drive(0, 12'h050, 4'b1010, pack(17, 18, 19, 20), 2, 24'h000000, 2'd0, 1'b1, 1);
        drive(0, 12'h060, 4'b0001, pack(21, 0, 0, 0), 1, 24'h000010, 2'd0, 1'b0, 1);
        drive(0, 12'h061, 4'b1000, pack(0, 0, 0, 22), 1, 24'hC0FFEE, 2'd3, 1'b0, 1);
        drive(0, 12'h070, 4'b0010, pack(0, 23, 0, 0), 1, 24'h00BEEF, 2'd1, 1'b0, 2);
        drive(1, 12'h100, 4'b1000, pack(0, 0, 0, 3), 1, 24'h0000FF, 2'd3, 1'b0, 1);

        // Reset while B is in WAIT: the read happened, the pixel must not.
        while (!ready_b) @(negedge clock);
        off_s = 12'h200; en_s = 4'b0001; ids_s = pack(1, 0, 0, 0);
        req_b = 1'b1;
        rb.push_back({5'd1, 12'h200});
        @(posedge clock);
        #1 req_b = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_rd_en", 32'(rd_en_b), 0);
        check("midrst_valid", 32'(valid_b), 0);
        check("midrst_pixel", 32'(pixel_b), 0);
        check("midrst_saida_b", 32'(b_b), 0);
        check("midrst_addr", 32'(addr_b), 0);
        check("midrst_hit", 32'(hit_b), 0);
        check("midrst_none", 32'(none_b), 0);
        check("midrst_ready", 32'(ready_b), 0);
        check("midrst_pixel_a", 32'(pixel_a), 0);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("postrst_ready_b", 32'(ready_b), 1);

        drive(1, 12'h210, 4'b0011, pack(5, 6, 0, 0), 2, 24'hABCDEF, 2'd1, 1'b0, 1);
        drive(0, 12'h010, 4'b1111, pack(1, 2, 3, 4), 1, 24'hFF0000, 2'd0, 1'b0, 1);

        for (int i = 0; i < 100; i++) begin
            if (qa.size() == 0 && qb.size() == 0 && ra.size() == 0 && rb.size() == 0) break;
            @(negedge clock);
        end
        check("outstanding_pixels", 32'(qa.size() + qb.size()), 0);
        check("outstanding_reads", 32'(ra.size() + rb.size()), 0);
        repeat (10) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
